// File: rtl/jt51_wrfifo_pkg.sv
// Shared types and constants for the jt51 CPU write FIFO front-end.
package jt51_wrfifo_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  // Drain FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One queued CPU access: a0 travels with its byte so address/data pairing survives.
  typedef struct packed {
    logic              a0;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [4:0] STATUS_PAD = 5'b0;

endpackage

// File: rtl/jt51_wrfifo_mem.sv
// DEPTH x 9 FIFO storage: registered write port, asynchronous read at rd_ptr.
module jt51_wrfifo_mem
  import jt51_wrfifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_ptr,
  output entry_t        rd_data_c
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/jt51_wrfifo.sv
// YM2151 CPU write front-end: edge-detected pushes into a FIFO drained into jt51_mmr.
// Optional JT51_WRFIFO_STATS_EN adds drop_cnt and max_level statistics outputs.
module jt51_wrfifo
  import jt51_wrfifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 2,
  parameter int unsigned BUSY_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        a0,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic        flag_A,
  input  logic        flag_B,
  output logic        mmr_a0,
  output logic [7:0]  mmr_din,
  output logic        mmr_write,
  input  logic        mmr_busy,
  output logic [AW:0] level,
  output logic        overflow
`ifdef JT51_WRFIFO_STATS_EN
  ,
  output logic [7:0]  drop_cnt,
  output logic [AW:0] max_level
`endif
);

  localparam int unsigned LW       = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic          write_c;
  logic          write_l;
  logic          push_c;
  logic          pop_c;
  logic          accept_c;
  logic          drop_c;
  logic          busy_c;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          flag_A_s;
  logic          flag_B_s;
  state_t        state;
  state_t        state_nx;
  logic [1:0]    bsh;
  logic [1:0]    bsh_nx;
  logic          mmr_write_nx;
  entry_t        wr_entry_c;
  entry_t        head_c;

  // One entry per CPU access regardless of strobe length.
  assign write_c    = !cs_n && !wr_n;
  assign push_c     = write_c && !write_l;
  assign accept_c   = push_c && ((level != FULL_LVL) || pop_c);
  assign drop_c     = push_c && !accept_c;
  assign wr_entry_c = {a0, d_in};

  jt51_wrfifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .we        (accept_c),
    .wr_ptr    (wr_ptr),
    .wr_data   (wr_entry_c),
    .rd_ptr    (rd_ptr),
    .rd_data_c (head_c)
  );

  generate
    if (BUSY_MODE == 0) begin : g_busy_legacy
      assign busy_c = (level != '0) || (state != IDLE);
    end else begin : g_busy_full
      assign busy_c = (level == FULL_LVL);
    end
  endgenerate

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bsh       <= 2'b00;
      mmr_write <= 1'b0;
    end else begin
      state     <= state_nx;
      bsh       <= bsh_nx;
      mmr_write <= mmr_write_nx;
    end
  end

  // Drain FSM next state: pop in IDLE, hold request until busy seen, wait for busy to fall.
  always_comb begin
    state_nx     = state;
    bsh_nx       = bsh;
    mmr_write_nx = mmr_write;
    pop_c        = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop_c        = 1'b1;
          mmr_write_nx = 1'b1;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        if (mmr_busy) begin
          mmr_write_nx = 1'b0;
          bsh_nx       = 2'b01;
          state_nx     = WAIT;
        end
      end
      WAIT: begin
        bsh_nx = {bsh[0], mmr_busy};
        if (bsh == 2'b10) state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        mmr_write_nx = 1'b0;
      end
    endcase
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_l  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      write_l <= write_c;
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Head entry presented to mmr on the pop edge, then held until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmr_a0  <= 1'b0;
      mmr_din <= 8'h00;
    end else if (pop_c) begin
      mmr_a0  <= head_c.a0;
      mmr_din <= head_c.data;
    end
  end

  // Status byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_A_s <= 1'b0;
      flag_B_s <= 1'b0;
      d_out    <= 8'h00;
    end else begin
      flag_A_s <= flag_A;
      flag_B_s <= flag_B;
      d_out    <= {busy_c, STATUS_PAD, flag_B_s, flag_A_s};
    end
  end

`ifdef JT51_WRFIFO_STATS_EN
  // Saturating drop counter and occupancy high-water mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= 8'h00;
      max_level <= '0;
    end else begin
      if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (level > max_level) max_level <= level;
    end
  end
`endif

endmodule

// File: tb/tb_jt51_wrfifo.sv
// Directed bench for jt51_wrfifo: legacy (u0) and full-only (u1) busy policies on shared stimulus.
module tb_jt51_wrfifo;
  import jt51_wrfifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n, wr_n, a0;
  logic [7:0] d_in;
  logic       flag_A, flag_B;
  logic       mmr_busy;

  logic [7:0] d_out0, d_out1, mmr_din0, mmr_din1;
  logic       mmr_a0_0, mmr_a0_1, mmr_write0, mmr_write1, overflow0, overflow1;
  logic [2:0] level0, level1;
`ifdef JT51_WRFIFO_STATS_EN
  logic [7:0] drop_cnt0, drop_cnt1;
  logic [2:0] max_level0, max_level1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  jt51_wrfifo #(.DEPTH(4), .AW(2), .BUSY_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .d_in(d_in),
    .d_out(d_out0), .flag_A(flag_A), .flag_B(flag_B), .mmr_a0(mmr_a0_0),
    .mmr_din(mmr_din0), .mmr_write(mmr_write0), .mmr_busy(mmr_busy),
    .level(level0), .overflow(overflow0)
`ifdef JT51_WRFIFO_STATS_EN
    , .drop_cnt(drop_cnt0), .max_level(max_level0)
`endif
  );

  jt51_wrfifo #(.DEPTH(4), .AW(2), .BUSY_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .d_in(d_in),
    .d_out(d_out1), .flag_A(flag_A), .flag_B(flag_B), .mmr_a0(mmr_a0_1),
    .mmr_din(mmr_din1), .mmr_write(mmr_write1), .mmr_busy(mmr_busy),
    .level(level1), .overflow(overflow1)
`ifdef JT51_WRFIFO_STATS_EN
    , .drop_cnt(drop_cnt1), .max_level(max_level1)
`endif
  );

  // mmr model: busy for 4 cycles per request, forced high by hold_busy, silent when mute.
  logic hold_busy = 1'b0;
  logic mute      = 1'b0;
  int   bcnt      = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt     = 0;
      mmr_busy = 1'b0;
    end else if (hold_busy) begin
      bcnt     = 0;
      mmr_busy = 1'b1;
    end else begin
      if (bcnt != 0) bcnt = bcnt - 1;
      else if (mmr_write0 && !mute) bcnt = 4;
      mmr_busy = (bcnt != 0);
    end
  end

  // Transfer log: one record per rising mmr_write of u0.
  logic [8:0] xq[$];
  logic       mw_prev = 1'b0;
  always @(negedge clk) begin
    if (mmr_write0 && !mw_prev) xq.push_back({mmr_a0_0, mmr_din0});
    mw_prev = mmr_write0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; d_in = d;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int t = 0;
    while (xq.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk(name, 32'(xq.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_hold(input logic h);
    @(posedge clk);
    #1 hold_busy = h;
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         hold;
    logic       fa;
    logic       fb;
    logic       exp_a0;
    logic [7:0] exp_din;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{a0:1'b0, d:8'h20, hold:1, fa:1'b0, fb:1'b0, exp_a0:1'b0, exp_din:8'h20, exp_dout:8'h00};
    vecs[1] = '{a0:1'b1, d:8'hC7, hold:3, fa:1'b1, fb:1'b0, exp_a0:1'b1, exp_din:8'hC7, exp_dout:8'h01};
    vecs[2] = '{a0:1'b0, d:8'hFF, hold:2, fa:1'b0, fb:1'b1, exp_a0:1'b0, exp_din:8'hFF, exp_dout:8'h02};
    vecs[3] = '{a0:1'b1, d:8'h00, hold:1, fa:1'b1, fb:1'b1, exp_a0:1'b1, exp_din:8'h00, exp_dout:8'h03};
    vecs[4] = '{a0:1'b1, d:8'h5A, hold:5, fa:1'b0, fb:1'b0, exp_a0:1'b1, exp_din:8'h5A, exp_dout:8'h00};
    vecs[5] = '{a0:1'b0, d:8'hA5, hold:1, fa:1'b1, fb:1'b0, exp_a0:1'b0, exp_din:8'hA5, exp_dout:8'h01};

    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; d_in = 8'h00;
    flag_A = 1'b0; flag_B = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(d_out0), 32'h00);
    chk("rst_write", 32'(mmr_write0), 32'd0);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_overflow", 32'(overflow0), 32'd0);
    chk("rst_mmr_a0", 32'(mmr_a0_0), 32'd0);
    chk("rst_mmr_din", 32'(mmr_din0), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, strobe held 10 cycles: busy bit spans edges 2..8 after assertion.
    xq.delete();
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; d_in = 8'h14;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("single_busy0_k%0d", k), 32'(d_out0[7]), 32'((k >= 2) && (k <= 8)));
      chk($sformatf("single_busy1_k%0d", k), 32'(d_out1[7]), 32'd0);
      if (k == 2) begin
        chk("single_write_hi", 32'(mmr_write0), 32'd1);
        chk("single_din", 32'(mmr_din0), 32'h14);
      end
    end
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("single_count", 32'(xq.size()), 32'd1);
    if (xq.size() > 0) chk("single_entry", 32'(xq[0]), 32'h014);
    chk("single_dout_end", 32'(d_out0), 32'h00);

    // Table of isolated writes with status flags.
    for (int i = 0; i < 6; i++) begin
      xq.delete();
      flag_A = vecs[i].fa;
      flag_B = vecs[i].fb;
      cpu_write(vecs[i].a0, vecs[i].d, vecs[i].hold);
      wait_xfers(1, 40, $sformatf("vec%0d_timeout", i));
      if (xq.size() > 0) begin
        chk($sformatf("vec%0d_a0", i), 32'(xq[0][8]), 32'(vecs[i].exp_a0));
        chk($sformatf("vec%0d_din", i), 32'(xq[0][7:0]), 32'(vecs[i].exp_din));
      end
      repeat (12) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_dout0", i), 32'(d_out0), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_dout1", i), 32'(d_out1), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_count", i), 32'(xq.size()), 32'd1);
    end
    flag_A = 1'b0; flag_B = 1'b0;

    // Burst of 6 with mmr held busy: 01 drains, 02..05 fill, 06 dropped.
    do_reset();
    xq.delete();
    set_hold(1'b1);
    for (int i = 1; i <= 6; i++) begin
      cpu_write(i[0], 8'(i), 1);
      if (i == 4) begin
        @(posedge clk); #1;
        chk("burst_l3_busy1", 32'(d_out1[7]), 32'd0);
        chk("burst_l3_busy0", 32'(d_out0[7]), 32'd1);
      end
      if (i == 5) begin
        @(posedge clk); #1;
        chk("burst_full_busy1", 32'(d_out1[7]), 32'd1);
        chk("burst_full_ovf", 32'(overflow0), 32'd0);
      end
    end
    #1;
    chk("burst_level", 32'(level0), 32'd4);
    chk("burst_overflow", 32'(overflow0), 32'd1);
    set_hold(1'b0);
    wait_xfers(5, 200, "burst_timeout");
    repeat (20) @(posedge clk);
    #1;
    chk("burst_count", 32'(xq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (xq.size() > i) chk($sformatf("burst_x%0d", i), 32'(xq[i]), 32'({1'((i + 1) % 2), 8'(i + 1)}));
    chk("burst_ovf_sticky", 32'(overflow0), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_clears_ovf", 32'(overflow0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Push of AA lands on the same edge as a pop with the FIFO full.
    xq.delete();
    set_hold(1'b1);
    cpu_write(1'b0, 8'h10, 1);
    cpu_write(1'b1, 8'h11, 1);
    cpu_write(1'b0, 8'h22, 1);
    cpu_write(1'b1, 8'h33, 1);
    cpu_write(1'b0, 8'h44, 1);
    #1;
    chk("simul_pre_level", 32'(level0), 32'd4);
    set_hold(1'b0);
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    cpu_write(1'b1, 8'hAA, 1);
    #1;
    chk("simul_level", 32'(level0), 32'd4);
    chk("simul_overflow", 32'(overflow0), 32'd0);
    wait_xfers(6, 200, "simul_timeout");
    if (xq.size() >= 6) begin
      chk("simul_x1", 32'(xq[1]), 32'h111);
      chk("simul_x4", 32'(xq[4]), 32'h044);
      chk("simul_last", 32'(xq[5]), 32'h1AA);
    end

    // Reset while ISSUE is stuck waiting for busy with two entries queued.
    repeat (20) @(posedge clk);
    do_reset();
    xq.delete();
    @(posedge clk); #1 mute = 1'b1;
    cpu_write(1'b1, 8'h55, 1);
    cpu_write(1'b0, 8'h66, 1);
    cpu_write(1'b1, 8'h77, 1);
    @(posedge clk); #1;
    chk("mid_pre_level", 32'(level0), 32'd2);
    chk("mid_pre_write", 32'(mmr_write0), 32'd1);
    chk("mid_pre_dout", 32'(d_out0), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_write", 32'(mmr_write0), 32'd0);
    chk("mid_level", 32'(level0), 32'd0);
    chk("mid_overflow", 32'(overflow0), 32'd0);
    chk("mid_dout", 32'(d_out0), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 mute = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_no_more", 32'(xq.size()), 32'd1);
    chk("mid_level_after", 32'(level0), 32'd0);

`ifdef JT51_WRFIFO_STATS_EN
    // 300 pushes against a stalled mmr.
    do_reset();
    set_hold(1'b1);
    for (int i = 0; i < 300; i++) cpu_write(1'b0, 8'(i), 1);
    @(posedge clk); #1;
    chk("stats_drop", 32'(drop_cnt0), 32'hFF);
    chk("stats_max", 32'(max_level0), 32'd4);
    set_hold(1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
